// File: rtl/bless_router_param.sv
// Bufferless deflection (BLESS) mesh router node.
// Stage 1 registers the four link inputs. Stage 2 ranks flits oldest-first,
// ejects one local flit, allocates output ports (productive X, then Y, else
// deflect), and injects one flit from the local FIFO into a leftover port.
module bless_router_param #(
    parameter int MY_X      = 0,
    parameter int MY_Y      = 0,
    parameter int COORD_W   = 3,
    parameter int AGE_W     = 4,
    parameter int DATA_W    = 32,
    parameter int INJ_DEPTH = 4,
    parameter int CNT_W     = 16,
    localparam int FLIT_W   = AGE_W + 2*COORD_W + DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          din_valid,
    input  logic [4*FLIT_W-1:0] din,
    output logic [3:0]          dout_valid,
    output logic [4*FLIT_W-1:0] dout,
    input  logic                inj_valid,
    output logic                inj_ready,
    input  logic [FLIT_W-1:0]   inj_flit,
    output logic                ej_valid,
    output logic [FLIT_W-1:0]   ej_flit,
    output logic [CNT_W-1:0]    defl_count
);
    localparam int PTR_W = $clog2(INJ_DEPTH);
    localparam logic [COORD_W-1:0] MY_XC = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_YC = COORD_W'(MY_Y);
    localparam int X_LSB = DATA_W + COORD_W;
    localparam int Y_LSB = DATA_W;

    // Productive output set for a destination; port order W, E, S, N.
    function automatic logic [3:0] prod_ports(input logic [COORD_W-1:0] dx,
                                              input logic [COORD_W-1:0] dy);
        logic [3:0] m;
        m[0] = (dx < MY_XC);
        m[1] = (dx > MY_XC);
        m[2] = (dy < MY_YC);
        m[3] = (dy > MY_YC);
        return m;
    endfunction

    // One-hot grant: free productive X port, then free productive Y port,
    // otherwise the lowest-index free port.
    function automatic logic [3:0] pick_port(input logic [3:0] prod, input logic [3:0] free);
        logic [3:0] ok;
        ok = prod & free;
        if (ok[1:0] != 2'b00) return {2'b00, ok[1:0]};
        if (ok[3:2] != 2'b00) return {ok[3:2], 2'b00};
        return free & (~free + 4'd1);
    endfunction

    // Age increment on a hop, saturating at all-ones.
    function automatic logic [FLIT_W-1:0] bump_age(input logic [FLIT_W-1:0] f);
        logic [FLIT_W-1:0] r;
        r = f;
        if (f[FLIT_W-1 -: AGE_W] != '1)
            r[FLIT_W-1 -: AGE_W] = f[FLIT_W-1 -: AGE_W] + AGE_W'(1);
        return r;
    endfunction

    logic [3:0][FLIT_W-1:0] din_2d;
    logic [3:0][FLIT_W-1:0] s1_flit_q;
    logic [3:0]             s1_vld_q;

    logic [3:0][FLIT_W-1:0] out_d, out_q;
    logic [3:0]             out_vld_d, out_vld_q;
    logic                   ej_vld_d, ej_vld_q;
    logic [FLIT_W-1:0]      ej_d, ej_q;
    logic [CNT_W-1:0]       defl_d, defl_q;
    logic [CNT_W:0]         defl_sum;

    logic [FLIT_W-1:0]      fifo_mem [INJ_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]         cnt_q;
    logic                   fifo_full, fifo_empty, push, pop;

    logic [1:0]             rank [4];
    logic [3:0]             is_local;
    logic                   ej_hit;
    logic [1:0]             ej_idx;
    logic [3:0]             free, prod, grant;
    logic [2:0]             ndefl;
    logic [FLIT_W-1:0]      inj_head;

    assign din_2d     = din;
    assign fifo_full  = (cnt_q == (PTR_W+1)'(INJ_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign inj_ready  = reset & ~fifo_full;
    assign push       = inj_valid & inj_ready;

    // Stage 1: capture link inputs, zeroing idle ports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q  <= '0;
            s1_flit_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            s1_vld_q <= din_valid;
            for (int i = 0; i < 4; i++)
                s1_flit_q[i] <= din_valid[i] ? din_2d[i] : '0;
        end
    end

    // Stage 2: rank, eject, allocate and inject.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        rank      = '{default: 2'd0};
        is_local  = '0;
        ej_hit    = 1'b0;
        ej_idx    = 2'd0;
        free      = 4'hF;
        prod      = '0;
        grant     = '0;
        ndefl     = 3'd0;
        out_d     = '0;
        out_vld_d = '0;
        pop       = 1'b0;
        inj_head  = fifo_mem[rd_ptr_q];
        inj_head[FLIT_W-1 -: AGE_W] = '0;

        for (int i = 0; i < 4; i++) begin
            is_local[i] = (s1_flit_q[i][X_LSB +: COORD_W] == MY_XC) &&
                          (s1_flit_q[i][Y_LSB +: COORD_W] == MY_YC);
            for (int j = 0; j < 4; j++) begin
                if (j != i && s1_vld_q[j] &&
                    ((s1_flit_q[j][FLIT_W-1 -: AGE_W] > s1_flit_q[i][FLIT_W-1 -: AGE_W]) ||
                     ((s1_flit_q[j][FLIT_W-1 -: AGE_W] == s1_flit_q[i][FLIT_W-1 -: AGE_W]) && j < i)))
                    rank[i] = rank[i] + 2'd1;
            end
        end

        // Highest-priority local flit ejects.
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++)
                if (!ej_hit && s1_vld_q[i] && is_local[i] && rank[i] == 2'(r)) begin
                    ej_hit = 1'b1;
                    ej_idx = 2'(i);
                end

        // Port allocation in priority order; local flits have no productive port.
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++)
                if (s1_vld_q[i] && rank[i] == 2'(r) && !(ej_hit && ej_idx == 2'(i))) begin
                    prod  = prod_ports(s1_flit_q[i][X_LSB +: COORD_W], s1_flit_q[i][Y_LSB +: COORD_W]);
                    grant = pick_port(prod, free);
                    if ((prod & free) == 4'd0) ndefl = ndefl + 3'd1;
                    for (int p = 0; p < 4; p++)
                        if (grant[p]) begin
                            out_vld_d[p] = 1'b1;
                            out_d[p]     = bump_age(s1_flit_q[i]);
                        end
                    free = free & ~grant;
                end

        // Injection takes whatever port is left, at lowest priority.
        if (!fifo_empty && free != 4'd0) begin
            pop   = 1'b1;
            prod  = prod_ports(inj_head[X_LSB +: COORD_W], inj_head[Y_LSB +: COORD_W]);
            grant = pick_port(prod, free);
            if ((prod & free) == 4'd0) ndefl = ndefl + 3'd1;
            for (int p = 0; p < 4; p++)
                if (grant[p]) begin
                    out_vld_d[p] = 1'b1;
                    out_d[p]     = bump_age(inj_head);
                end
        end

        ej_vld_d = ej_hit;
        ej_d     = ej_hit ? s1_flit_q[ej_idx] : '0;
        defl_sum = {1'b0, defl_q} + (CNT_W+1)'(ndefl);
        defl_d   = defl_sum[CNT_W] ? '1 : defl_sum[CNT_W-1:0];
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            out_vld_q <= '0;
            ej_vld_q  <= 1'b0;
            ej_q      <= '0;
            defl_q    <= '0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            ej_vld_q  <= ej_vld_d;
            ej_q      <= ej_d;
            defl_q    <= defl_d;
        end
    end

    // Injection FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (!push && pop) cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

    // Injection FIFO storage.
    // NOTE: storage is not reset; occupancy gates every read so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= inj_flit;
    end

    assign dout_valid = out_vld_q;
    assign dout       = out_q;
    assign ej_valid   = ej_vld_q;
    assign ej_flit    = ej_q;
    assign defl_count = defl_q;
endmodule

// File: tb/tb_bless_router_param.sv
// Directed bench for bless_router_param at node (2,2) with an 8-bit
// deflection counter; expectations are queued per driven cycle and
// compared when the pipeline delivers them two edges later.
module tb_bless_router_param;
    localparam int MY_X = 2, MY_Y = 2, COORD_W = 3, AGE_W = 4, DATA_W = 32;
    localparam int INJ_DEPTH = 4, CNT_W = 8;
    localparam int FLIT_W = AGE_W + 2*COORD_W + DATA_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef struct packed {
        logic [31:0]            id;
        logic [31:0]            due;
        logic [3:0]             vld;
        logic [3:0][FLIT_W-1:0] f;
        logic                   ejv;
        flit_t                  ejf;
        logic [CNT_W-1:0]       defl;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [3:0]          din_valid;
    logic [4*FLIT_W-1:0] din;
    logic [3:0]          dout_valid;
    logic [4*FLIT_W-1:0] dout;
    logic                inj_valid;
    logic                inj_ready;
    flit_t               inj_flit;
    logic                ej_valid;
    flit_t               ej_flit;
    logic [CNT_W-1:0]    defl_count;

    bless_router_param #(
        .MY_X(MY_X), .MY_Y(MY_Y), .COORD_W(COORD_W), .AGE_W(AGE_W),
        .DATA_W(DATA_W), .INJ_DEPTH(INJ_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .din_valid(din_valid), .din(din),
        .dout_valid(dout_valid), .dout(dout),
        .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_flit(inj_flit),
        .ej_valid(ej_valid), .ej_flit(ej_flit),
        .defl_count(defl_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cycle = 0, step_id = 0;
    int exp_defl = 0, exp_ndefl = 0;
    exp_t sb[$];
    exp_t e;
    logic [3:0]             drv_vld;
    logic [3:0][FLIT_W-1:0] drv_f;
    logic                   drv_inj;
    flit_t                  drv_inj_f;

    function automatic flit_t mk(input int age, input int x, input int y, input logic [31:0] data);
        return {AGE_W'(age), COORD_W'(x), COORD_W'(y), data};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input exp_t x);
        check($sformatf("s%0d dout_valid", x.id), 64'(dout_valid), 64'(x.vld));
        for (int p = 0; p < 4; p++)
            check($sformatf("s%0d dout[%0d]", x.id, p), 64'(dout[p*FLIT_W +: FLIT_W]), 64'(x.f[p]));
        check($sformatf("s%0d ej_valid", x.id), 64'(ej_valid), 64'(x.ejv));
        check($sformatf("s%0d ej_flit", x.id), 64'(ej_flit), 64'(x.ejf));
        check($sformatf("s%0d defl_count", x.id), 64'(defl_count), 64'(x.defl));
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        cycle++;
        while (sb.size() != 0 && sb[0].due == 32'(cycle)) begin
            x = sb.pop_front();
            compare(x);
        end
    endtask

    task automatic clear_step();
        drv_vld = '0;
        for (int i = 0; i < 4; i++) drv_f[i] = {FLIT_W{1'b1}} ^ FLIT_W'(i * 7);
        drv_inj   = 1'b0;
        drv_inj_f = {FLIT_W{1'b1}};
        e         = '0;
        exp_ndefl = 0;
    endtask

    task automatic step();
        din_valid = drv_vld;
        din       = drv_f;
        inj_valid = drv_inj;
        inj_flit  = drv_inj_f;
        exp_defl  = exp_defl + exp_ndefl;
        if (exp_defl > CNT_MAX) exp_defl = CNT_MAX;
        e.defl = CNT_W'(exp_defl);
        e.due  = 32'(cycle + 2);
        e.id   = 32'(step_id);
        step_id++;
        sb.push_back(e);
        tick();
    endtask

    // Four flits, one per productive direction; no deflections.
    task automatic load_four();
        drv_vld  = 4'b1111;
        drv_f[0] = mk(1, 5, 2, 32'hF0);
        drv_f[1] = mk(1, 0, 2, 32'hF1);
        drv_f[2] = mk(1, 2, 5, 32'hF2);
        drv_f[3] = mk(1, 2, 0, 32'hF3);
        e.vld  = 4'b1111;
        e.f[1] = mk(2, 5, 2, 32'hF0);
        e.f[0] = mk(2, 0, 2, 32'hF1);
        e.f[3] = mk(2, 2, 5, 32'hF2);
        e.f[2] = mk(2, 2, 0, 32'hF3);
    endtask

    initial begin
        reset = 1'b0;
        clear_step();
        din_valid = '0; din = '0; inj_valid = 1'b0; inj_flit = '0;
        tick(); tick();
        check("rst dout_valid", 64'(dout_valid), 64'd0);
        check("rst dout", 64'(|dout), 64'd0);
        check("rst ej_valid", 64'(ej_valid), 64'd0);
        check("rst defl", 64'(defl_count), 64'd0);
        reset = 1'b1;
        #1;
        check("rst inj_ready", 64'(inj_ready), 64'd1);

        // Single flit heading east.
        clear_step();
        drv_vld = 4'b0001; drv_f[0] = mk(3, 5, 2, 32'hA1);
        e.vld = 4'b0010; e.f[1] = mk(4, 5, 2, 32'hA1);
        step();

        // Older W wins E; younger S deflects to W.
        clear_step();
        drv_vld = 4'b0101; drv_f[0] = mk(7, 4, 2, 32'hB0); drv_f[2] = mk(2, 4, 2, 32'hB2);
        e.vld = 4'b0011; e.f[1] = mk(8, 4, 2, 32'hB0); e.f[0] = mk(3, 4, 2, 32'hB2);
        exp_ndefl = 1;
        step();

        // Three local flits: age tie goes to W for ejection, others deflect.
        clear_step();
        drv_vld = 4'b0111;
        drv_f[0] = mk(5, 2, 2, 32'hC0); drv_f[1] = mk(5, 2, 2, 32'hC1); drv_f[2] = mk(1, 2, 2, 32'hC2);
        e.ejv = 1'b1; e.ejf = mk(5, 2, 2, 32'hC0);
        e.vld = 4'b0011; e.f[0] = mk(6, 2, 2, 32'hC1); e.f[1] = mk(2, 2, 2, 32'hC2);
        exp_ndefl = 2;
        step();

        // X before Y; loser falls back to its productive Y port.
        clear_step();
        drv_vld = 4'b0011; drv_f[0] = mk(2, 5, 5, 32'hD0); drv_f[1] = mk(1, 6, 6, 32'hD1);
        e.vld = 4'b1010; e.f[1] = mk(3, 5, 5, 32'hD0); e.f[3] = mk(2, 6, 6, 32'hD1);
        step();

        // Age saturation, and westward X taken before northward Y.
        clear_step();
        drv_vld = 4'b0011; drv_f[0] = mk(15, 5, 2, 32'hE0); drv_f[1] = mk(4, 1, 3, 32'hE1);
        e.vld = 4'b0011; e.f[1] = mk(15, 5, 2, 32'hE0); e.f[0] = mk(5, 1, 3, 32'hE1);
        step();

        // All outputs taken: injection blocked, then injected on idle cycle.
        check("pre inj_ready", 64'(inj_ready), 64'd1);
        clear_step();
        load_four();
        drv_inj = 1'b1; drv_inj_f = mk(9, 2, 6, 32'hF9);
        step();
        clear_step();
        e.vld = 4'b1000; e.f[3] = mk(1, 2, 6, 32'hF9);
        step();
        clear_step();
        step();

        // Injection alongside traffic: injected flit deflected to lowest free port.
        clear_step();
        drv_vld = 4'b0001; drv_f[0] = mk(0, 5, 2, 32'h60);
        drv_inj = 1'b1; drv_inj_f = mk(3, 5, 2, 32'h61);
        e.vld = 4'b0011; e.f[1] = mk(1, 5, 2, 32'h60); e.f[0] = mk(1, 5, 2, 32'h61);
        exp_ndefl = 1;
        step();
        clear_step();
        step();

        // Fill FIFO while every output is busy.
        for (int k = 1; k <= 4; k++) begin
            clear_step();
            load_four();
            drv_inj = 1'b1; drv_inj_f = mk(0, 2, 6, 32'h700 + 32'(k));
            step();
            check($sformatf("fill%0d inj_ready", k), 64'(inj_ready), (k < 4) ? 64'd1 : 64'd0);
        end
        clear_step();
        load_four();
        drv_inj = 1'b1; drv_inj_f = mk(0, 2, 6, 32'h7FF);
        step();
        check("full inj_ready", 64'(inj_ready), 64'd0);

        // Asynchronous reset mid-stream.
        #2 reset = 1'b0;
        #1;
        check("arst dout_valid", 64'(dout_valid), 64'd0);
        check("arst dout", 64'(|dout), 64'd0);
        check("arst ej_valid", 64'(ej_valid), 64'd0);
        check("arst ej_flit", 64'(ej_flit), 64'd0);
        check("arst defl", 64'(defl_count), 64'd0);
        sb.delete();
        exp_defl = 0;
        din_valid = '0; inj_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("rel inj_ready", 64'(inj_ready), 64'd1);
        clear_step();
        step();
        clear_step();
        step();

        // Deflection counter saturation: three deflections per cycle.
        for (int k = 0; k < 90; k++) begin
            clear_step();
            drv_vld = 4'b1111;
            for (int i = 0; i < 4; i++) drv_f[i] = mk(0, 5, 2, 32'(k * 4 + i));
            e.vld  = 4'b1111;
            e.f[1] = mk(1, 5, 2, 32'(k * 4 + 0));
            e.f[0] = mk(1, 5, 2, 32'(k * 4 + 1));
            e.f[2] = mk(1, 5, 2, 32'(k * 4 + 2));
            e.f[3] = mk(1, 5, 2, 32'(k * 4 + 3));
            exp_ndefl = 3;
            step();
        end
        clear_step();
        step();
        clear_step();
        step();
        tick(); tick();
        check("sat defl", 64'(defl_count), 64'(CNT_MAX));
        check("sb drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
